param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH: default 4; data bits per entry; minimum 4.
REQ-002 Parameter DEPTH: default 8; entry count; power of 2, minimum 2; AW = log2(DEPTH).
REQ-003 Parameter AF_LVL: default 6; almost_full threshold, range 1..DEPTH.
REQ-004 Parameter AE_LVL: default 1; almost_empty threshold, range 0..DEPTH-1.
REQ-005 Parameter SCAN_DIV: default 1024; clk cycles per display digit; minimum 1.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 enq  input  1  enqueue request; level input, acted on at its rising transition.
REQ-009 deq  input  1  dequeue request; level input, acted on at its rising transition.
REQ-010 in  input  WIDTH  enqueue data.
REQ-011 out  output  WIDTH  last dequeued data, registered.
REQ-012 full, emp, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-013 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-014 ovf, udf  output  1 each  sticky overflow and underflow error flags.
REQ-015 an  output  AW  physical slot index currently displayed.
REQ-016 hexplay_data  output  4  low nibble of the displayed slot.

Function
REQ-017 Enqueue and dequeue pulses: each SHALL be generated internally from a registered previous sample. A pulse is true at the first rising edge where the input is sampled 1 after being sampled 0. Holding the input high SHALL produce exactly one operation.
REQ-018 Enqueue: accepted on an enqueue pulse when !full, or when full and a dequeue is accepted in the same cycle; on acceptance, in is written at the tail, the tail advances and wraps modulo DEPTH.
REQ-019 Dequeue: accepted on a dequeue pulse when !emp; on acceptance, out is loaded with the head entry and the head advances modulo DEPTH; otherwise out holds.
REQ-020 Simultaneous pulses, 0 < count < DEPTH: both SHALL be accepted; count unchanged.
REQ-021 Simultaneous pulses, full: both SHALL be accepted; count stays DEPTH; out takes the old head.
REQ-022 Simultaneous pulses, empty: only the enqueue SHALL be accepted; the dequeue is rejected and sets udf; no fall-through to out.
REQ-023 A rejected enqueue (full, no accepted dequeue) SHALL NOT write storage and SHALL set ovf. A rejected dequeue (empty) SHALL set udf. ovf and udf clear only on reset.
REQ-024 count SHALL be a register updated in the same edge as the operation: +1 for enqueue only, -1 for dequeue only, unchanged otherwise.
REQ-025 Flags SHALL be decoded combinationally from count:
- full = (count==DEPTH)
- emp = (count==0)
- almost_full = (count>=AF_LVL)
- almost_empty = (count<=AE_LVL)
REQ-026 Display scan:
- A prescaler advances a digit index i every SCAN_DIV cycles.
- i runs 0..count-1 and then wraps to 0.
- If count drops to i or below, i SHALL reset to 0 on the next edge.
- an = (head + i) mod DEPTH.
- hexplay_data = bits [3:0] of storage[an].
REQ-027 When emp, an SHALL be 0 and hexplay_data SHALL be 0.
REQ-028 Storage SHALL be an internal register array with one write port and two read ports (dequeue, display).

Reset
REQ-029 Assertion of rst SHALL immediately force:
- head, tail, count, out, ovf, udf, the prescaler and i to 0;
- therefore emp=1, almost_empty=1, full=0, almost_full=0.
REQ-030 On reset, the enq/deq previous-sample registers SHALL be set to 1, so an input held high across reset release produces no operation.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries. The first operation after release SHALL behave as on an empty FIFO.

Verification (WIDTH=4, DEPTH=8, AF_LVL=6, AE_LVL=1, SCAN_DIV=4)
REQ-033 Fill sequence:
- Stimulus: pulse enq with in=1..8.
- After each pulse, count increments.
- almost_full at count 6; full at count 8.
- A ninth enq pulse -> ovf=1, count stays 8.
REQ-034 Drain sequence:
- Stimulus: from full, pulse deq 8 times.
- out = 1,2,...,8 in order; emp=1 after the eighth.
- A ninth deq pulse -> udf=1, out holds 8.
REQ-035 Wrap-around: enq 5, deq 5, enq 6 -> head=5, tail wraps to 3. Dequeued order equals enqueue order; count=0 at end.
REQ-036 Simultaneous events:
- Full, enq+deq same cycle with in=F -> count=8, out = old head, F stored at the tail.
- Empty, enq+deq same cycle with in=A -> count=1, udf=1, out unchanged.
REQ-037 Level hold and display:
- enq held high 20 cycles -> exactly one entry written.
- With 3 entries, an cycles through the 3 occupied slots only, each held 4 cycles; hexplay_data matches the stored nibbles.
REQ-038 Reset: assert rst low mid-fill at count=5 -> count=0, emp=1, out=0, ovf=0, an=0, hexplay_data=0 without waiting for a clock edge.

Source files
------------

// File: rtl/param_fifo_if.sv
// Handshake/data bundle for param_fifo: enqueue/dequeue requests in, data, flags
// and the scanned display outputs back.
interface param_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             enq;
  logic             deq;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             emp;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             ovf;
  logic             udf;
  logic [AW-1:0]    an;
  logic [3:0]       hexplay_data;

  modport master (
    output enq, deq, in,
    input  out, full, emp, almost_full, almost_empty, count, ovf, udf, an, hexplay_data
  );

  modport slave (
    input  enq, deq, in,
    output out, full, emp, almost_full, almost_empty, count, ovf, udf, an, hexplay_data
  );
endinterface

// File: rtl/param_fifo.sv
// Edge-triggered register FIFO with occupancy flags, sticky error flags and a
// time-multiplexed scan of the occupied slots for a hex display.
module param_fifo #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LVL   = 6,
  parameter int AE_LVL   = 1,
  parameter int SCAN_DIV = 1024
) (
  input logic        clk,
  input logic        rst,
  param_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail, idx, scan_slot;
  logic [AW:0]      count;
  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] out_r;
  logic             ovf_r, udf_r;
  logic             enq_prev, deq_prev;
  logic             enq_pls, deq_pls, enq_acc, deq_acc, tick;
  logic             full_w, emp_w;

  // Previous samples reset to 1 so a level held across reset release is ignored
  assign enq_pls = bus.enq & ~enq_prev;
  assign deq_pls = bus.deq & ~deq_prev;

  assign full_w  = (count == (AW+1)'(DEPTH));
  assign emp_w   = (count == '0);
  assign deq_acc = deq_pls & ~emp_w;
  assign enq_acc = enq_pls & (~full_w | deq_acc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enq_prev <= 1'b1;
      deq_prev <= 1'b1;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      out_r    <= '0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      enq_prev <= bus.enq;
      deq_prev <= bus.deq;
      if (enq_acc) tail <= tail + AW'(1);
      if (deq_acc) begin
        head  <= head + AW'(1);
        out_r <= mem[head];
      end
      if (enq_pls && !enq_acc) ovf_r <= 1'b1;
      if (deq_pls && !deq_acc) udf_r <= 1'b1;
      case ({enq_acc, deq_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (enq_acc) mem[tail] <= bus.in;
  end

  assign tick = (pre == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      // Pull the index back when the occupancy shrinks underneath it
      if (count <= {1'b0, idx})
        idx <= '0;
      else if (tick)
        idx <= (({1'b0, idx} + (AW+1)'(1)) >= count) ? '0 : idx + AW'(1);
    end
  end

  assign scan_slot = head + idx;

  assign bus.out          = out_r;
  assign bus.full         = full_w;
  assign bus.emp          = emp_w;
  assign bus.almost_full  = (count >= (AW+1)'(AF_LVL));
  assign bus.almost_empty = (count <= (AW+1)'(AE_LVL));
  assign bus.count        = count;
  assign bus.ovf          = ovf_r;
  assign bus.udf          = udf_r;
  assign bus.an           = emp_w ? '0 : scan_slot;
  assign bus.hexplay_data = emp_w ? 4'h0 : mem[scan_slot][3:0];
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: stimulus queues expected values, a negedge
// monitor pops and compares them once their cycle has arrived.
module tb_param_fifo;
  localparam int WIDTH = 4, DEPTH = 8, AF_LVL = 6, AE_LVL = 1, SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum int {F_OUT, F_CNT, F_FULL, F_EMP, F_AF, F_AE, F_OVF, F_UDF, F_AN, F_HEX} fld_e;
  typedef struct {
    int    cyc;
    fld_e  f;
    int    val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(fld_e f);
    case (f)
      F_OUT:   return int'(bus.out);
      F_CNT:   return int'(bus.count);
      F_FULL:  return int'(bus.full);
      F_EMP:   return int'(bus.emp);
      F_AF:    return int'(bus.almost_full);
      F_AE:    return int'(bus.almost_empty);
      F_OVF:   return int'(bus.ovf);
      F_UDF:   return int'(bus.udf);
      F_AN:    return int'(bus.an);
      F_HEX:   return int'(bus.hexplay_data);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input string name, input fld_e f, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.f    = f;
    e.val  = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor: compares every expectation whose cycle has been reached
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        chk(e.name, sample(e.f), e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit e, input bit d, input int din);
    bus.in  = din[WIDTH-1:0];
    bus.enq = e;
    bus.deq = d;
    tick();
  endtask

  task automatic rel();
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    tick();
  endtask

  task automatic chk_idle_reset();
    chk("rst_count", int'(bus.count), 0);
    chk("rst_emp", int'(bus.emp), 1);
    chk("rst_ae", int'(bus.almost_empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_af", int'(bus.almost_full), 0);
    chk("rst_out", int'(bus.out), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_udf", int'(bus.udf), 0);
    chk("rst_an", int'(bus.an), 0);
    chk("rst_hex", int'(bus.hexplay_data), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, prev_a, run, nxt;
    bit seen_tr;
    int slot_val [DEPTH];

    bus.enq = 1'b0;
    bus.deq = 1'b0;
    bus.in  = '0;
    #1 rst = 1'b0;
    #1 chk_idle_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Fill 1..8, then one rejected enqueue
    for (int k = 1; k <= 8; k++) begin
      op(1, 0, k);
      push("fill_cnt", F_CNT, k);
      push("fill_af", F_AF, (k >= 6) ? 1 : 0);
      push("fill_full", F_FULL, (k == 8) ? 1 : 0);
      push("fill_emp", F_EMP, 0);
      rel();
    end
    op(1, 0, 9);
    push("ovf_set", F_OVF, 1);
    push("ovf_cnt", F_CNT, 8);
    push("ovf_full", F_FULL, 1);
    rel();

    // Drain: slot 0 must still hold 1, proving the rejected write was dropped
    for (int k = 1; k <= 8; k++) begin
      op(0, 1, 0);
      push("drain_out", F_OUT, k);
      push("drain_cnt", F_CNT, 8 - k);
      push("drain_emp", F_EMP, (k == 8) ? 1 : 0);
      push("drain_ae", F_AE, (8 - k <= 1) ? 1 : 0);
      rel();
    end
    op(0, 1, 0);
    push("udf_set", F_UDF, 1);
    push("udf_out_hold", F_OUT, 8);
    push("udf_cnt", F_CNT, 0);
    rel();

    // Wrap-around: head moves to 5, tail wraps to 3
    for (int k = 0; k < 5; k++) begin op(1, 0, 10 + k); rel(); end
    for (int k = 0; k < 5; k++) begin
      op(0, 1, 0);
      push("wrap1_out", F_OUT, 10 + k);
      rel();
    end
    for (int k = 1; k <= 6; k++) begin op(1, 0, k); rel(); end
    push("wrap_cnt6", F_CNT, 6);
    push("wrap_af6", F_AF, 1);
    for (int k = 1; k <= 6; k++) begin
      op(0, 1, 0);
      push("wrap2_out", F_OUT, k);
      rel();
    end
    push("wrap_cnt0", F_CNT, 0);
    push("wrap_ovf_sticky", F_OVF, 1);
    push("wrap_udf_sticky", F_UDF, 1);
    tick();

    // Reset mid-fill at count 5, observed before any clock edge
    for (int k = 0; k < 5; k++) begin op(1, 0, 7); rel(); end
    push("mid_cnt5", F_CNT, 5);
    tick();
    rst = 1'b0;
    #1 chk_idle_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Empty: enqueue accepted, dequeue rejected, no fall-through
    op(1, 1, 10);
    push("se_cnt", F_CNT, 1);
    push("se_udf", F_UDF, 1);
    push("se_out", F_OUT, 0);
    push("se_ovf", F_OVF, 0);
    rel();
    for (int k = 1; k <= 7; k++) begin op(1, 0, k); rel(); end
    push("sf_pre_full", F_FULL, 1);
    tick();

    // Full: both accepted, old head out, F lands at the tail
    op(1, 1, 15);
    push("sf_cnt", F_CNT, 8);
    push("sf_out", F_OUT, 10);
    push("sf_full", F_FULL, 1);
    push("sf_ovf", F_OVF, 0);
    rel();
    for (int k = 1; k <= 8; k++) begin
      op(0, 1, 0);
      push("sf_drain_out", F_OUT, (k == 8) ? 15 : k);
      rel();
    end
    push("sf_cnt0", F_CNT, 0);
    tick();

    // Level hold: 20 high cycles give one entry
    bus.in  = 4'd3;
    bus.enq = 1'b1;
    repeat (20) tick();
    push("hold_cnt", F_CNT, 1);
    rel();
    op(1, 0, 4); rel();
    op(1, 0, 5); rel();
    push("disp_cnt", F_CNT, 3);
    tick();

    // Head sits at 1, so slots 1..3 hold 3,4,5
    slot_val = '{default: -1};
    slot_val[1] = 3;
    slot_val[2] = 4;
    slot_val[3] = 5;
    seen_tr = 1'b0;
    run = 0;
    @(negedge clk);
    prev_a = int'(bus.an);
    for (int s = 0; s < 32; s++) begin
      if (s > 0) @(negedge clk);
      a = int'(bus.an);
      chk("disp_an_range", (a >= 1 && a <= 3) ? 1 : 0, 1);
      chk("disp_hex", int'(bus.hexplay_data), (a >= 1 && a <= 3) ? slot_val[a] : -1);
      if (a != prev_a) begin
        nxt = (prev_a == 3) ? 1 : prev_a + 1;
        chk("disp_an_seq", a, nxt);
        if (seen_tr) chk("disp_hold", run, SCAN_DIV);
        seen_tr = 1'b1;
        run = 1;
        prev_a = a;
      end else begin
        run++;
      end
    end
    chk("disp_saw_step", int'(seen_tr), 1);
    #1;

    for (int k = 3; k <= 5; k++) begin
      op(0, 1, 0);
      push("disp_drain_out", F_OUT, k);
      rel();
    end
    push("empty_an", F_AN, 0);
    push("empty_hex", F_HEX, 0);
    push("empty_emp", F_EMP, 1);

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
